// File: rtl/wrr_stream_mux_pkg.sv
// Shared types and elaboration helpers for the weighted-round-robin packet mux.
package wrr_stream_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register stage; accepts a new beat whenever it is empty
// or being drained in the same cycle.
module stream_reg_slice #(
  parameter int PAYLOAD_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  output logic                     ready_o,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [PAYLOAD_WIDTH-1:0] payload_o
);

  logic                     valid_q;
  logic                     valid_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic [PAYLOAD_WIDTH-1:0] payload_d;

  assign ready_o   = ~valid_q | ready_i;
  assign valid_o   = valid_q;
  assign payload_o = payload_q;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (valid_i && ready_o) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/wrr_stream_mux.sv
// Packet-level N:1 stream mux: weighted-round-robin credit pick at packet
// boundaries, grant held until last beat, registered output stage.
module wrr_stream_mux
  import wrr_stream_mux_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CREDIT_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int SEL_WIDTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CREDIT_WIDTH*WIDTH-1:0] credits,
  input  logic [WIDTH-1:0]              in_valid,
  output logic [WIDTH-1:0]              in_ready,
  input  logic [DATA_WIDTH*WIDTH-1:0]   in_data,
  input  logic [WIDTH-1:0]              in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SEL_WIDTH-1:0]          out_src
);

  localparam int PAYLOAD_WIDTH = SEL_WIDTH + 1 + DATA_WIDTH;

  if (SEL_WIDTH < clog2(WIDTH)) begin : g_sel_check
    $error("SEL_WIDTH is too narrow to index WIDTH ports");
  end

  state_e                   state_q;
  logic [SEL_WIDTH-1:0]     sel_q;
  logic [WIDTH-1:0]         avail;
  logic [DATA_WIDTH-1:0]    data_arr [WIDTH];
  logic                     all_zero;
  logic                     req_one;
  logic                     win_valid;
  logic [SEL_WIDTH-1:0]     win_idx;
  logic                     pick;
  logic                     sel_valid;
  logic                     sel_last;
  logic                     accept;
  logic                     slice_ready;
  logic [PAYLOAD_WIDTH-1:0] slice_in;
  logic [PAYLOAD_WIDTH-1:0] slice_out;

  assign all_zero  = ~|avail;
  assign req_one   = (in_valid != '0) && ((in_valid & (in_valid - WIDTH'(1))) == '0);
  assign pick      = (state_q == IDLE) && win_valid;
  assign sel_valid = in_valid[sel_q];
  assign sel_last  = in_last[sel_q];
  assign accept    = (state_q == LOCK) && sel_valid && slice_ready;

  // A sole requester wins even without credit; otherwise lowest port with credit.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_one ? in_valid[i] : (in_valid[i] && avail[i])) begin
        win_valid = 1'b1;
        win_idx   = SEL_WIDTH'(i);
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_port
    logic [CREDIT_WIDTH-1:0] credit_q;
    logic [CREDIT_WIDTH-1:0] credit_d;

    assign avail[gi]    = (credit_q != '0);
    assign data_arr[gi] = in_data[DATA_WIDTH*gi +: DATA_WIDTH];
    assign in_ready[gi] = (state_q == LOCK) && (sel_q == SEL_WIDTH'(gi)) && slice_ready;

    // Reload wins over decrement; credit is charged once per packet at the pick.
    always_comb begin
      credit_d = credit_q;
      if (all_zero) begin
        credit_d = credits[CREDIT_WIDTH*gi +: CREDIT_WIDTH];
      end else if (pick && (win_idx == SEL_WIDTH'(gi)) && avail[gi]) begin
        credit_d = credit_q - CREDIT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        credit_q <= '0;
      end else begin
        credit_q <= credit_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            sel_q   <= win_idx;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (accept && sel_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slice_in = {sel_q, sel_last, data_arr[sel_q]};

  stream_reg_slice #(
    .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
  ) u_out_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (accept),
    .payload_i(slice_in),
    .ready_o  (slice_ready),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .payload_o(slice_out)
  );

  assign {out_src, out_last, out_data} = slice_out;

endmodule

// File: tb/tb_wrr_stream_mux.sv
// Scoreboard bench for wrr_stream_mux: per-port packet sources, expected beats
// queued up front and popped as the merged stream delivers them.
module tb_wrr_stream_mux;

  localparam int W  = 4;
  localparam int CW = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CW*W-1:0] credits;
  logic [W-1:0]    in_valid;
  logic [W-1:0]    in_ready;
  logic [DW*W-1:0] in_data;
  logic [W-1:0]    in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [SW-1:0]   out_src;

  always #5 clk = ~clk;

  wrr_stream_mux #(
    .WIDTH(W), .CREDIT_WIDTH(CW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .credits(credits),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  int pkt_len[W];
  int beat_idx[W];
  int pkt_cnt[W];
  int max_pkts[W];
  bit en[W];
  int first_fire[W];
  int last_done[W];

  int          cyc;
  logic [W-1:0] ir_s;
  logic        ov_s;
  logic [31:0] od_s;
  logic        ol_s;
  logic [1:0]  os_s;
  bit          out_fire_s;
  int          first_out_cyc;
  int          prev_out_cyc;
  bit          prev_out_last;
  bit          gap_chk;

  function automatic logic [31:0] mk(input int p, input int k, input int b);
    return {8'(160 + p), 8'(k), 16'(b)};
  endfunction

  task automatic push_exp(input int p, input int k, input int b, input bit l);
    beat_t e;
    e.src  = 2'(p);
    e.data = mk(p, k, b);
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      in_valid[i]          = en[i] && (pkt_cnt[i] < max_pkts[i]);
      in_data[i*DW +: DW]  = mk(i, pkt_cnt[i], beat_idx[i]);
      in_last[i]           = (beat_idx[i] == pkt_len[i] - 1);
    end
  endtask

  task automatic sample();
    beat_t e;
    beat_t got;
    ir_s       = in_ready;
    ov_s       = out_valid;
    od_s       = out_data;
    ol_s       = out_last;
    os_s       = out_src;
    out_fire_s = out_valid && out_ready;
    for (int i = 0; i < W; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        if (first_fire[i] < 0) first_fire[i] = cyc;
        if (in_last[i]) begin
          last_done[i] = cyc;
          beat_idx[i]  = 0;
          pkt_cnt[i]   = pkt_cnt[i] + 1;
        end else begin
          beat_idx[i] = beat_idx[i] + 1;
        end
      end
    end
    if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
    if (out_fire_s) begin
      got.src  = out_src;
      got.data = out_data;
      got.last = out_last;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: cycle %0d got src=%0d data=%h last=%0d, required no beat",
                 cyc, out_src, out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_beat: cycle %0d got src=%0d data=%h last=%0d, required src=%0d data=%h last=%0d",
                   cyc, got.src, got.data, got.last, e.src, e.data, e.last);
        end else begin
          $display("beat cycle=%0d src=%0d data=%h last=%0d", cyc, got.src, got.data, got.last);
        end
      end
      if (gap_chk && prev_out_cyc >= 0) begin
        checks++;
        if ((cyc - prev_out_cyc) != (prev_out_last ? 2 : 1)) begin
          errors++;
          $display("FAIL beat_gap: cycle %0d gap %0d, required %0d",
                   cyc, cyc - prev_out_cyc, prev_out_last ? 2 : 1);
        end
      end
      prev_out_cyc  = cyc;
      prev_out_last = out_last;
    end
  endtask

  // Called at a falling edge: drive, sample before the rising edge, advance.
  task automatic cycle();
    drive();
    #3;
    sample();
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_src();
    for (int i = 0; i < W; i++) begin
      en[i]         = 1'b0;
      beat_idx[i]   = 0;
      pkt_cnt[i]    = 0;
      max_pkts[i]   = 0;
      pkt_len[i]    = 1;
      first_fire[i] = -1;
      last_done[i]  = -1;
    end
    first_out_cyc = -1;
    prev_out_cyc  = -1;
    prev_out_last = 1'b0;
    gap_chk       = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_src();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    credits = {4'd1, 4'd1, 4'd1, 4'd1};
    clear_src();
    drive();
    @(negedge clk);
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (out_last  !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
    if (out_data  !== '0)   begin errors++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    if (out_src   !== '0)   begin errors++; $display("FAIL rst_out_src: got %0d, required 0", out_src); end
    if (in_ready  !== '0)   begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    $display("reset check done");
  endtask

  task automatic test_wrr();
    credits = {4'd1, 4'd1, 4'd1, 4'd2};
    apply_reset();
    max_pkts[0] = 4; max_pkts[1] = 2; max_pkts[2] = 2; max_pkts[3] = 2;
    for (int i = 0; i < W; i++) en[i] = 1'b1;
    push_exp(0, 0, 0, 1); push_exp(0, 1, 0, 1); push_exp(1, 0, 0, 1);
    push_exp(2, 0, 0, 1); push_exp(3, 0, 0, 1);
    push_exp(0, 2, 0, 1); push_exp(0, 3, 0, 1); push_exp(1, 1, 0, 1);
    push_exp(2, 1, 0, 1); push_exp(3, 1, 0, 1);
    drain("wrr", 80);
    checks++;
    if (first_fire[0] != 2) begin
      errors++;
      $display("FAIL wrr_first_accept: got cycle %0d, required 2", first_fire[0]);
    end
  endtask

  task automatic test_sole_zero_credit();
    credits = {4'd1, 4'd0, 4'd1, 4'd2};
    apply_reset();
    pkt_len[2] = 3; max_pkts[2] = 3; en[2] = 1'b1;
    gap_chk = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 3; b++) push_exp(2, k, b, b == 2);
    drain("sole", 60);
    checks += 2;
    if (first_fire[2] != 1) begin
      errors++;
      $display("FAIL sole_first_accept: got cycle %0d, required 1", first_fire[2]);
    end
    if (first_out_cyc != 2) begin
      errors++;
      $display("FAIL sole_latency: got out_valid at cycle %0d, required 2", first_out_cyc);
    end
  endtask

  task automatic test_hold_grant();
    int viol;
    int n;
    viol = 0;
    n    = 0;
    credits = {4'd1, 4'd1, 4'd1, 4'd1};
    apply_reset();
    pkt_len[0] = 4; max_pkts[0] = 1; en[0] = 1'b1;
    pkt_len[1] = 2; max_pkts[1] = 1;
    for (int b = 0; b < 4; b++) push_exp(0, 0, b, b == 3);
    for (int b = 0; b < 2; b++) push_exp(1, 0, b, b == 1);
    while (exp_q.size() > 0 && n < 40) begin
      if (beat_idx[0] >= 2 || pkt_cnt[0] > 0) en[1] = 1'b1;
      cycle();
      if (pkt_cnt[0] == 0 && ir_s[1]) viol++;
      n++;
    end
    checks += 3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_drain: %0d beats outstanding, required 0", exp_q.size());
    end
    if (viol != 0) begin
      errors++;
      $display("FAIL hold_in_ready1: got %0d cycles of in_ready[1] during port0 packet, required 0", viol);
    end
    if (first_fire[1] != last_done[0] + 2) begin
      errors++;
      $display("FAIL hold_bubble: port1 first accept cycle %0d, required %0d",
               first_fire[1], last_done[0] + 2);
    end
  endtask

  task automatic test_backpressure();
    int outs;
    int n;
    logic [31:0] cap_d;
    logic        cap_l;
    logic [1:0]  cap_s;
    outs = 0;
    n    = 0;
    cap_d = '0; cap_l = 1'b0; cap_s = '0;
    credits = {4'd1, 4'd1, 4'd1, 4'd1};
    apply_reset();
    pkt_len[0] = 8; max_pkts[0] = 1; en[0] = 1'b1;
    for (int b = 0; b < 8; b++) push_exp(0, 0, b, b == 7);
    while (outs < 3 && n < 40) begin
      cycle();
      if (out_fire_s) outs++;
      n++;
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks += 2;
      if (ov_s !== 1'b1) begin errors++; $display("FAIL bp_out_valid: stall %0d got %b, required 1", k, ov_s); end
      if (ir_s[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready: stall %0d got %b, required 0", k, ir_s[0]); end
      if (k == 0) begin
        cap_d = od_s; cap_l = ol_s; cap_s = os_s;
        checks++;
        if (od_s !== mk(0, 0, 3)) begin
          errors++;
          $display("FAIL bp_held_data: got %h, required %h", od_s, mk(0, 0, 3));
        end
      end else begin
        checks++;
        if (od_s !== cap_d || ol_s !== cap_l || os_s !== cap_s) begin
          errors++;
          $display("FAIL bp_stable: stall %0d got data=%h last=%0d src=%0d, required data=%h last=%0d src=%0d",
                   k, od_s, ol_s, os_s, cap_d, cap_l, cap_s);
        end
      end
    end
    out_ready = 1'b1;
    drain("bp", 40);
  endtask

  task automatic test_credit_skip();
    credits = {4'd1, 4'd1, 4'd0, 4'd0};
    apply_reset();
    for (int i = 0; i < W; i++) begin
      en[i] = 1'b1;
      max_pkts[i] = 10;
    end
    for (int k = 0; k < 3; k++) begin
      push_exp(2, k, 0, 1);
      push_exp(3, k, 0, 1);
    end
    drain("skip", 60);
    checks += 2;
    if (first_fire[0] != -1) begin errors++; $display("FAIL skip_port0: got accept at cycle %0d, required none", first_fire[0]); end
    if (first_fire[1] != -1) begin errors++; $display("FAIL skip_port1: got accept at cycle %0d, required none", first_fire[1]); end
  endtask

  task automatic test_no_grant_cycle();
    credits = {4'd0, 4'd0, 4'd1, 4'd1};
    apply_reset();
    en[0] = 1'b1; max_pkts[0] = 2;
    en[1] = 1'b1; max_pkts[1] = 2;
    push_exp(0, 0, 0, 1); push_exp(1, 0, 0, 1);
    push_exp(0, 1, 0, 1); push_exp(1, 1, 0, 1);
    drain("nogrant", 40);
    checks++;
    if (first_fire[0] != 2) begin
      errors++;
      $display("FAIL nogrant_first_accept: got cycle %0d, required 2", first_fire[0]);
    end
  endtask

  task automatic test_async_reset();
    int outs;
    int n;
    outs = 0;
    n    = 0;
    credits = {4'd1, 4'd1, 4'd1, 4'd1};
    apply_reset();
    pkt_len[0] = 6; max_pkts[0] = 1; en[0] = 1'b1;
    for (int b = 0; b < 6; b++) push_exp(0, 0, b, b == 5);
    while (outs < 2 && n < 40) begin
      cycle();
      if (out_fire_s) outs++;
      n++;
    end
    out_ready = 1'b0;
    drive();
    #2;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b, required 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b, required 0", out_valid); end
    if (in_ready !== '0) begin errors++; $display("FAIL arst_in_ready: got %b, required 0", in_ready); end
    $display("async reset asserted mid-packet");
    clear_src();
    en[0] = 1'b1; max_pkts[0] = 1;
    en[1] = 1'b1; max_pkts[1] = 1;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    push_exp(0, 0, 0, 1);
    push_exp(1, 0, 0, 1);
    drain("arst", 40);
    checks++;
    if (first_fire[0] != 2) begin
      errors++;
      $display("FAIL arst_first_accept: got cycle %0d, required 2", first_fire[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    cyc       = 0;
    test_reset();
    test_wrr();
    test_sole_zero_credit();
    test_hold_grant();
    test_backpressure();
    test_credit_skip();
    test_no_grant_cycle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
